// File: rtl/stream_parity_checker.sv
// ============================================================================
// Module   : stream_parity_checker
// Function : Framed stream parity stage: accumulates per-frame XOR parity,
//            checks each word against its sideband parity bit and reports
//            parity/error/word count on a valid/ready result port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_parity_checker #(
    parameter int WIDTH = 8,
    parameter int ODD   = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_par,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic             out_err,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [0:0]       S_ACCUM   = 1'b0;
    localparam logic [0:0]       S_DONE    = 1'b1;
    localparam logic             c_ODD     = (ODD != 0);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]       r_state;
    logic             r_in_ready;
    logic             r_acc;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_parity;
    logic             r_out_err;
    logic [CNT_W-1:0] r_out_count;

    logic             w_accept;
    logic             w_word_par;
    logic             w_acc_nxt;
    logic             w_err_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_accept   = in_valid & r_in_ready;
    assign w_word_par = ^in_data;
    assign w_acc_nxt  = r_acc ^ w_word_par;
    assign w_err_nxt  = r_err | ((w_word_par ^ c_ODD) != in_par);
    assign w_cnt_nxt  = (r_cnt == c_CNT_MAX) ? c_CNT_MAX : r_cnt + 1'b1;

    // Handshake flags are dedicated registers so neither port sees decode logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_ACCUM;
            r_in_ready   <= 1'b1;
            r_acc        <= 1'b0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
            r_out_parity <= 1'b0;
            r_out_err    <= 1'b0;
            r_out_count  <= '0;
        end else begin
            case (r_state)
                S_ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_acc_nxt;
                        r_err <= w_err_nxt;
                        r_cnt <= w_cnt_nxt;
                        if (in_last) begin
                            r_state      <= S_DONE;
                            r_in_ready   <= 1'b0;
                            r_out_parity <= w_acc_nxt ^ c_ODD;
                            r_out_err    <= w_err_nxt;
                            r_out_count  <= w_cnt_nxt;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state    <= S_ACCUM;
                        r_in_ready <= 1'b1;
                        r_acc      <= 1'b0;
                        r_err      <= 1'b0;
                        r_cnt      <= '0;
                    end
                end
                default: begin
                    r_state    <= S_ACCUM;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_state[0];
    assign out_parity = r_out_parity;
    assign out_err    = r_out_err;
    assign out_count  = r_out_count;

endmodule

`default_nettype wire

// File: tb/tb_stream_parity_checker.sv
// Testbench for stream_parity_checker: a default instance (8-bit, even, 8-bit count)
// and a narrow instance (2-bit, odd, 2-bit count) checked against a counting model.
`default_nettype none

module tb_stream_parity_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       a_in_valid = 1'b0, a_in_ready, a_in_par = 1'b0, a_in_last = 1'b0;
    logic [7:0] a_in_data = '0;
    logic       a_out_valid, a_out_ready = 1'b0, a_out_parity, a_out_err;
    logic [7:0] a_out_count;

    logic       b_in_valid = 1'b0, b_in_ready, b_in_par = 1'b0, b_in_last = 1'b0;
    logic [1:0] b_in_data = '0;
    logic       b_out_valid, b_out_ready = 1'b0, b_out_parity, b_out_err;
    logic [1:0] b_out_count;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    stream_parity_checker #(.WIDTH(8), .ODD(0), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_par(a_in_par), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_parity(a_out_parity), .out_err(a_out_err), .out_count(a_out_count)
    );

    stream_parity_checker #(.WIDTH(2), .ODD(1), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_par(b_in_par), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_parity(b_out_parity), .out_err(b_out_err), .out_count(b_out_count)
    );

    // Observed status vectors: {in_ready, out_valid, out_parity, out_err, out_count}
    wire [11:0] a_obs = {a_in_ready, a_out_valid, a_out_parity, a_out_err, a_out_count};
    wire [5:0]  b_obs = {b_in_ready, b_out_valid, b_out_parity, b_out_err, b_out_count};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_send(input logic [7:0] d, input logic p, input logic l);
        a_in_valid = 1'b1; a_in_data = d; a_in_par = p; a_in_last = l;
        step();
        a_in_valid = 1'b0; a_in_data = 8'($urandom); a_in_par = 1'($urandom);
        a_in_last = 1'($urandom);
    endtask

    task automatic b_send(input logic [1:0] d, input logic p, input logic l);
        b_in_valid = 1'b1; b_in_data = d; b_in_par = p; b_in_last = l;
        step();
        b_in_valid = 1'b0; b_in_data = 2'($urandom); b_in_par = 1'($urandom);
        b_in_last = 1'($urandom);
    endtask

    task automatic a_handshake();
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
    endtask

    task automatic b_handshake();
        b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        n_total++;
        if (a_obs !== 12'b1_0_0_0_00000000)
            $display("FAIL reset_a: got %h expected %h", a_obs, 12'b1_0_0_0_00000000);
        else n_pass++;
        n_total++;
        if (b_obs !== 6'b1_0_0_0_00)
            $display("FAIL reset_b: got %h expected %h", b_obs, 6'b1_0_0_0_00);
        else n_pass++;
    endtask

    task automatic test_two_word_frame();
        a_send(8'h01, 1'b1, 1'b0);
        a_send(8'h03, 1'b0, 1'b1);
        n_total++;
        if (a_obs !== {1'b0, 1'b1, 1'b1, 1'b0, 8'd2})
            $display("FAIL two_word: got %h expected %h", a_obs, {1'b0, 1'b1, 1'b1, 1'b0, 8'd2});
        else n_pass++;
    endtask

    task automatic test_hold_result();
        for (int i = 0; i < 5; i++) begin
            a_in_valid = 1'b1; a_in_data = 8'($urandom); a_in_last = 1'b1;
            step();
            n_total++;
            if (a_obs !== {1'b0, 1'b1, 1'b1, 1'b0, 8'd2})
                $display("FAIL hold_%0d: got %h expected %h", i, a_obs, {1'b0, 1'b1, 1'b1, 1'b0, 8'd2});
            else n_pass++;
        end
        a_in_valid = 1'b0;
        a_handshake();
        n_total++;
        if ({a_in_ready, a_out_valid} !== 2'b10)
            $display("FAIL bubble: got %b expected %b", {a_in_ready, a_out_valid}, 2'b10);
        else n_pass++;
        a_send(8'h00, 1'b0, 1'b1);
        n_total++;
        if (a_obs !== {1'b0, 1'b1, 1'b0, 1'b0, 8'd1})
            $display("FAIL after_hold: got %h expected %h", a_obs, {1'b0, 1'b1, 1'b0, 1'b0, 8'd1});
        else n_pass++;
        a_handshake();
    endtask

    task automatic test_single_word();
        a_send(8'hFF, 1'b1, 1'b1);
        n_total++;
        if (a_obs !== {1'b0, 1'b1, 1'b0, 1'b1, 8'd1})
            $display("FAIL single_word: got %h expected %h", a_obs, {1'b0, 1'b1, 1'b0, 1'b1, 8'd1});
        else n_pass++;
        a_handshake();
    endtask

    task automatic test_reset_mid_frame();
        a_send(8'hA5, 1'b1, 1'b0);
        a_send(8'h3C, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_total++;
        if (a_obs !== 12'b1_0_0_0_00000000)
            $display("FAIL mid_reset_state: got %h expected %h", a_obs, 12'b1_0_0_0_00000000);
        else n_pass++;
        a_send(8'h07, 1'b1, 1'b1);
        n_total++;
        if (a_obs !== {1'b0, 1'b1, 1'b1, 1'b0, 8'd1})
            $display("FAIL mid_reset_frame: got %h expected %h", a_obs, {1'b0, 1'b1, 1'b1, 1'b0, 8'd1});
        else n_pass++;
        a_handshake();
    endtask

    task automatic test_saturation();
        int   ones;
        logic [7:0] d;
        ones = 0;
        for (int i = 0; i < 300; i++) begin
            d = 8'($urandom);
            ones += $countones(d);
            a_send(d, 1'($countones(d) % 2), (i == 299));
        end
        n_total++;
        if (a_obs !== {1'b0, 1'b1, 1'(ones % 2), 1'b0, 8'd255})
            $display("FAIL sat_a: got %h expected %h", a_obs, {1'b0, 1'b1, 1'(ones % 2), 1'b0, 8'd255});
        else n_pass++;
        a_handshake();
        for (int i = 0; i < 6; i++) b_send(2'b00, 1'b1, (i == 5));
        n_total++;
        if (b_obs !== {1'b0, 1'b1, 1'b1, 1'b0, 2'd3})
            $display("FAIL sat_b: got %h expected %h", b_obs, {1'b0, 1'b1, 1'b1, 1'b0, 2'd3});
        else n_pass++;
        b_handshake();
    endtask

    task automatic test_width2_sweep();
        logic exp_par;
        int   ones;
        for (int d = 0; d < 4; d++) begin
            for (int p = 0; p < 2; p++) begin
                b_send(2'(d), 1'(p), 1'b1);
                exp_par = 1'(($countones(2'(d)) + 1) % 2);
                n_total++;
                if (b_obs !== {1'b0, 1'b1, exp_par, (exp_par != 1'(p)), 2'd1})
                    $display("FAIL sweep_d%0d_p%0d: got %h expected %h", d, p, b_obs,
                             {1'b0, 1'b1, exp_par, (exp_par != 1'(p)), 2'd1});
                else n_pass++;
                b_handshake();
            end
        end
        ones = 0;
        for (int d = 0; d < 4; d++) begin
            ones += $countones(2'(d));
            b_send(2'(d), 1'(($countones(2'(d)) + 1) % 2), (d == 3));
        end
        exp_par = 1'((ones + 1) % 2);
        n_total++;
        if (b_obs !== {1'b0, 1'b1, exp_par, 1'b0, 2'd3})
            $display("FAIL sweep_all: got %h expected %h", b_obs, {1'b0, 1'b1, exp_par, 1'b0, 2'd3});
        else n_pass++;
        b_handshake();
    endtask

    task automatic test_random_frames();
        int         len, ones, n, hold;
        logic       err, good, p;
        logic [7:0] d;
        logic [11:0] exp;
        for (int f = 0; f < 20; f++) begin
            len = $urandom_range(1, 10);
            ones = 0; n = 0; err = 1'b0;
            for (int w = 0; w < len; w++) begin
                repeat ($urandom_range(0, 2)) begin
                    a_in_data = 8'($urandom); a_in_last = 1'b1;
                    step();
                end
                d = 8'($urandom);
                good = 1'($countones(d) % 2);
                p = ($urandom_range(0, 3) == 0) ? ~good : good;
                ones += $countones(d);
                n++;
                if (p != good) err = 1'b1;
                a_send(d, p, (w == len - 1));
            end
            exp = {1'b0, 1'b1, 1'(ones % 2), err, 8'((n > 255) ? 255 : n)};
            n_total++;
            if (a_obs !== exp)
                $display("FAIL rand_f%0d: got %h expected %h", f, a_obs, exp);
            else n_pass++;
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                a_in_valid = 1'b1; a_in_data = 8'($urandom);
                step();
                n_total++;
                if (a_obs !== exp)
                    $display("FAIL rand_hold_f%0d: got %h expected %h", f, a_obs, exp);
                else n_pass++;
            end
            a_in_valid = 1'b0;
            a_handshake();
            n_total++;
            if ({a_in_ready, a_out_valid} !== 2'b10)
                $display("FAIL rand_bubble_f%0d: got %b expected %b", f, {a_in_ready, a_out_valid}, 2'b10);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_two_word_frame();
        test_hold_result();
        test_single_word();
        test_reset_mid_frame();
        test_saturation();
        test_width2_sweep();
        test_random_frames();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
